// File: rtl/vx_raster_tile_writer.sv
// vx_raster_tile_writer
//   Write side of the raster tile buffer. Takes a binned stream of (tile, pid)
//   entries and writes each tile's pids as a packed list starting at pbuf_addr.
//   After the list, it writes an 8-byte header at tbuf_addr + 8*i in the layout
//   the raster memory unit fetches:
//     word0 = {tile_y, tile_x}
//     word1 = {pids_count, pids_offset}
//     pids_offset = (list_start - (hdr_addr + 4)) >> 2
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             pulse in IDLE: latch tbuf_addr/pbuf_addr, begin a frame
//   tbuf_addr         tile header base (8-byte aligned)
//   pbuf_addr         pid list base (4-byte aligned)
//   in_*              binned entry stream (valid/ready, in_last closes a tile)
//   finish            level: end of frame, no more entries
//   mem_req_*         word write requests (valid/ready)
//   mem_rsp_*         write acks (one per request, any order); ready tied 1
//   busy              high whenever not IDLE
//   done              one-cycle pulse when the frame has fully drained
//   tile_count        tiles written this frame, held until the next start
//   err               sticky error flag, cleared by start
module vx_raster_tile_writer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int PID_BITS    = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] tbuf_addr,
  input  logic [ADDR_WIDTH-1:0] pbuf_addr,
  input  logic                  in_valid,
  input  logic [15:0]           in_tile_x,
  input  logic [15:0]           in_tile_y,
  input  logic [PID_BITS-1:0]   in_pid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  finish,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_data,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           tile_count,
  output logic                  err
);

  localparam int PW = $clog2(MAX_PENDING) + 1;
  localparam logic [PW:0] MAX_P = (PW + 1)'(MAX_PENDING);

  typedef enum logic [2:0] {IDLE, PIDS, HDR0, HDR1, FLUSH} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] hdr_addr, pid_ptr, list_start, offset_full;
  logic [15:0]           tile_x, tile_y, cnt;
  logic                  tile_open;
  logic [PW-1:0]         pending;
  logic [PW:0]           inflight;
  logic                  req_fire, ack_ok, can_issue;
  logic                  load_pid, load_h0, load_h1;
  logic                  xy_mismatch, offset_ovf;

  assign req_fire      = mem_req_valid && mem_req_ready;
  assign ack_ok        = mem_rsp_valid && (pending != '0);
  assign mem_rsp_ready = 1'b1;
  assign busy          = (state != IDLE);

  // A held request is counted as already outstanding, so loading a new one
  // can never push the fired-but-unacked count past MAX_PENDING.
  assign inflight  = {1'b0, pending} + {{PW{1'b0}}, mem_req_valid};
  assign can_issue = (!mem_req_valid || req_fire) && (inflight < MAX_P);

  assign offset_full = (list_start - (hdr_addr + ADDR_WIDTH'(4))) >> 2;
  assign offset_ovf  = |offset_full[ADDR_WIDTH-1:16];
  assign xy_mismatch = tile_open && ((in_tile_x != tile_x) || (in_tile_y != tile_y));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load_pid   = 1'b0;
    load_h0    = 1'b0;
    load_h1    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = PIDS;
      end
      PIDS: begin
        in_ready = can_issue;
        if (in_valid && can_issue) begin
          load_pid = 1'b1;
          if (in_last) state_next = HDR0;
        end else if (!tile_open && !in_valid && finish) begin
          // An open tile is always closed by its in_last before flushing.
          state_next = FLUSH;
        end
      end
      HDR0: begin
        if (can_issue) begin
          load_h0    = 1'b1;
          state_next = HDR1;
        end
      end
      HDR1: begin
        if (can_issue) begin
          load_h1    = 1'b1;
          state_next = PIDS;
        end
      end
      FLUSH: begin
        if (pending == '0 && !mem_req_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      hdr_addr      <= '0;
      pid_ptr       <= '0;
      list_start    <= '0;
      tile_x        <= '0;
      tile_y        <= '0;
      cnt           <= '0;
      tile_open     <= 1'b0;
      pending       <= '0;
      tile_count    <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;

      case ({req_fire, ack_ok})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: ;
      endcase
      if (mem_rsp_valid && pending == '0) err <= 1'b1;

      if (req_fire) mem_req_valid <= 1'b0;

      if (state == IDLE && start) begin
        hdr_addr   <= tbuf_addr;
        pid_ptr    <= pbuf_addr;
        tile_count <= '0;
        tile_open  <= 1'b0;
        cnt        <= '0;
        err        <= 1'b0;
      end

      if (load_pid) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= pid_ptr;
        mem_req_data  <= 32'(in_pid);
        pid_ptr       <= pid_ptr + ADDR_WIDTH'(4);
        if (!tile_open) begin
          tile_x     <= in_tile_x;
          tile_y     <= in_tile_y;
          list_start <= pid_ptr;
          tile_open  <= 1'b1;
          cnt        <= 16'd1;
        end else begin
          // Mismatched entries are still appended to the open tile's list.
          if (xy_mismatch) err <= 1'b1;
          if (cnt == 16'hFFFF) err <= 1'b1;
          else                 cnt <= cnt + 16'd1;
        end
      end

      if (load_h0) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= hdr_addr;
        mem_req_data  <= {tile_y, tile_x};
      end

      if (load_h1) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= hdr_addr + ADDR_WIDTH'(4);
        mem_req_data  <= {cnt, offset_full[15:0]};
        hdr_addr      <= hdr_addr + ADDR_WIDTH'(8);
        tile_count    <= tile_count + 16'd1;
        tile_open     <= 1'b0;
        if (offset_ovf) err <= 1'b1;
        if (tile_count == 16'hFFFF) err <= 1'b1;
      end

      if (state == FLUSH && state_next == IDLE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_raster_tile_writer.sv
module tb_vx_raster_tile_writer;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, finish;
  logic [31:0] tbuf_addr, pbuf_addr, in_pid;
  logic [15:0] in_tile_x, in_tile_y;
  logic        in_ready, mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        busy, done, err;
  logic [15:0] tile_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          owed    = 0;
  int          credits = 0;
  logic        ack_en  = 1'b1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] pid;
    logic        last;
    int          exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vx_raster_tile_writer #(.ADDR_WIDTH(32), .PID_BITS(32), .MAX_PENDING(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .tbuf_addr(tbuf_addr), .pbuf_addr(pbuf_addr),
    .in_valid(in_valid), .in_tile_x(in_tile_x), .in_tile_y(in_tile_y),
    .in_pid(in_pid), .in_last(in_last), .in_ready(in_ready),
    .finish(finish),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .done(done), .tile_count(tile_count), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: logs every fired write and acks them in order of firing,
  // either freely (ack_en) or one per granted credit.
  always @(posedge clk) begin
    if (reset) begin
      owed    = 0;
      credits = 0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        log_addr.push_back(mem_req_addr);
        log_data.push_back(mem_req_data);
        owed++;
      end
      if (mem_rsp_valid) begin
        owed--;
        if (credits > 0) credits--;
      end
    end
  end

  always @(negedge clk) mem_rsp_valid = (ack_en || credits > 0) && (owed > 0);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkLog(input string name, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] aa, ad;
    if (idx < log_addr.size()) begin
      aa = log_addr[idx];
      ad = log_data[idx];
    end else begin
      aa = 32'hFFFF_FFFF;
      ad = 32'hFFFF_FFFF;
    end
    checkOutput({name, "_addr"}, aa, ea);
    checkOutput({name, "_data"}, ad, ed);
  endtask

  task automatic startFrame(input logic [31:0] tb, input logic [31:0] pb);
    log_addr.delete();
    log_data.delete();
    tbuf_addr = tb;
    pbuf_addr = pb;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Presents one entry and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] pid, input logic last);
    logic acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_tile_x = x;
    in_tile_y = y;
    in_pid    = pid;
    in_last   = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #4 acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("in_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic waitDone(input logic [15:0] exp_tiles, input logic exp_err);
    logic got;
    got    = 1'b0;
    finish = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    finish = 1'b0;
    checkOutput("done_seen", {31'd0, got}, 32'd1);
    checkOutput("tile_count", {16'd0, tile_count}, {16'd0, exp_tiles});
    checkOutput("err_at_done", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    vec_t t1[3];
    vec_t t2[4];
    int   stable;
    int   early;
    logic acc;

    t1 = '{'{16'd2, 16'd3, 32'd5, 1'b0, 0, 32'h2000, 32'd5},
           '{16'd2, 16'd3, 32'd7, 1'b0, 1, 32'h2004, 32'd7},
           '{16'd2, 16'd3, 32'd9, 1'b1, 2, 32'h2008, 32'd9}};
    t2 = '{'{16'd1, 16'd1, 32'd10, 1'b0, 0, 32'h1010, 32'd10},
           '{16'd1, 16'd1, 32'd11, 1'b1, 1, 32'h1014, 32'd11},
           '{16'd4, 16'd0, 32'd20, 1'b0, 4, 32'h1018, 32'd20},
           '{16'd4, 16'd0, 32'd21, 1'b1, 5, 32'h101C, 32'd21}};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; finish = 1'b0;
    tbuf_addr = '0; pbuf_addr = '0; in_pid = '0; in_tile_x = '0; in_tile_y = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_tile_count", {16'd0, tile_count}, 32'd0);

    $display("[TB] single tile");
    startFrame(32'h1000, 32'h2000);
    foreach (t1[i]) applyStimulus(t1[i].x, t1[i].y, t1[i].pid, t1[i].last);
    waitDone(16'd1, 1'b0);
    checkOutput("t1_writes", log_addr.size(), 32'd5);
    foreach (t1[i]) checkLog("t1_pid", t1[i].exp_idx, t1[i].exp_addr, t1[i].exp_data);
    checkLog("t1_hdr0", 3, 32'h1000, 32'h0003_0002);
    checkLog("t1_hdr1", 4, 32'h1004, 32'h0003_03FF);

    $display("[TB] two tiles");
    startFrame(32'h1000, 32'h1010);
    foreach (t2[i]) applyStimulus(t2[i].x, t2[i].y, t2[i].pid, t2[i].last);
    waitDone(16'd2, 1'b0);
    checkOutput("t2_writes", log_addr.size(), 32'd8);
    foreach (t2[i]) checkLog("t2_pid", t2[i].exp_idx, t2[i].exp_addr, t2[i].exp_data);
    checkLog("t2_a_hdr0", 2, 32'h1000, 32'h0001_0001);
    checkLog("t2_a_hdr1", 3, 32'h1004, 32'h0002_0003);
    checkLog("t2_b_hdr0", 6, 32'h1008, 32'h0000_0004);
    checkLog("t2_b_hdr1", 7, 32'h100C, 32'h0002_0003);

    $display("[TB] request stall");
    startFrame(32'h3000, 32'h4000);
    mem_req_ready = 1'b0;
    applyStimulus(16'd5, 16'd5, 32'd1, 1'b0);
    in_valid = 1'b1; in_tile_x = 16'd5; in_tile_y = 16'd5; in_pid = 32'd2; in_last = 1'b0;
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      if (mem_req_valid && mem_req_addr == 32'h4000 && mem_req_data == 32'd1 && !in_ready)
        stable++;
    end
    checkOutput("stall_stable_cycles", stable, 32'd20);
    #2 mem_req_ready = 1'b1;
    applyStimulus(16'd5, 16'd5, 32'd2, 1'b0);
    applyStimulus(16'd5, 16'd5, 32'd3, 1'b1);
    waitDone(16'd1, 1'b0);
    checkOutput("stall_writes", log_addr.size(), 32'd5);
    checkLog("stall_p0", 0, 32'h4000, 32'd1);
    checkLog("stall_p1", 1, 32'h4004, 32'd2);
    checkLog("stall_p2", 2, 32'h4008, 32'd3);
    checkLog("stall_hdr1", 4, 32'h3004, 32'h0003_03FF);

    $display("[TB] pending limit");
    ack_en = 1'b0;
    startFrame(32'h5000, 32'h6000);
    for (int k = 1; k <= 8; k++) applyStimulus(16'd3, 16'd4, 32'(k), 1'b0);
    in_valid = 1'b1; in_tile_x = 16'd3; in_tile_y = 16'd4; in_pid = 32'd9; in_last = 1'b0;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4 acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) early++;
    end
    checkOutput("full_no_accept", early, 32'd0);
    checkOutput("full_fires", log_addr.size(), 32'd8);
    credits = 1;
    acc = 1'b0;
    for (int i = 0; i < 20 && early == 0; i++) begin
      @(negedge clk);
      #4 acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    checkOutput("accept_after_ack", {31'd0, acc}, 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("fires_after_ack", log_addr.size(), 32'd9);
    checkOutput("no_extra_req", {31'd0, mem_req_valid}, 32'd0);
    #1 ack_en = 1'b1;
    applyStimulus(16'd3, 16'd4, 32'd10, 1'b1);
    waitDone(16'd1, 1'b0);
    checkLog("pend_p9", 9, 32'h6024, 32'd10);
    checkLog("pend_hdr0", 10, 32'h5000, 32'h0004_0003);
    checkLog("pend_hdr1", 11, 32'h5004, 32'h000A_03FF);

    $display("[TB] reset in header phase");
    startFrame(32'h7000, 32'h8000);
    applyStimulus(16'd1, 16'd2, 32'd3, 1'b1);
    checkOutput("busy_in_hdr0", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("mid_rst_tile_count", {16'd0, tile_count}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    startFrame(32'h7000, 32'h8000);
    applyStimulus(16'd6, 16'd7, 32'h55, 1'b1);
    waitDone(16'd1, 1'b0);
    checkOutput("after_rst_writes", log_addr.size(), 32'd3);
    checkLog("after_rst_pid", 0, 32'h8000, 32'h55);
    checkLog("after_rst_hdr0", 1, 32'h7000, 32'h0007_0006);
    checkLog("after_rst_hdr1", 2, 32'h7004, 32'h0001_03FF);

    $display("[TB] error cases");
    startFrame(32'h1000, 32'h2000);
    applyStimulus(16'd1, 16'd1, 32'd1, 1'b0);
    applyStimulus(16'd2, 16'd1, 32'd2, 1'b1);
    waitDone(16'd1, 1'b1);
    checkLog("mismatch_pid", 1, 32'h2004, 32'd2);
    startFrame(32'h0000_0000, 32'h0010_0000);
    checkOutput("err_cleared", {31'd0, err}, 32'd0);
    applyStimulus(16'd0, 16'd0, 32'd7, 1'b1);
    waitDone(16'd1, 1'b1);
    checkLog("ovf_hdr1", 2, 32'h0000_0004, 32'h0001_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
